// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: default field widths
// and the packed control bundle that a bubble clears in one assignment.
package id_ex_pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 3;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_write;
    logic               mem_read;
    logic               branch;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_hazard_unit.sv
// Combinational load-use compare: a load in EX whose destination (rt) is
// read by the instruction currently in ID. Writes to $0 never conflict.
module id_ex_hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             valid,
  input  logic             mem_read,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rt_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  output logic             hazard
);

  assign hazard = valid & mem_read & id_valid & (rt_ex != '0) &
                  ((rt_ex == rs_id) | (rt_ex == rt_id));

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with stall, flush, valid bit and a saturating bubble
// counter. Define ID_EX_HAZARD_EN to build in load-use detection.
module id_ex_pipe #(
  parameter int DATA_W  = id_ex_pipe_pkg::DATA_W,
  parameter int REG_W   = id_ex_pipe_pkg::REG_W,
  parameter int ALUOP_W = id_ex_pipe_pkg::ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic               RegWrite,
  input  logic               MemToReg,
  input  logic               MemWrite,
  input  logic               MemRead,
  input  logic               Branch,
  input  logic               ALUSrc,
  input  logic               RegDst,
  input  logic [ALUOP_W-1:0] AluOP,
  input  logic [DATA_W-1:0]  PCResult,
  input  logic [DATA_W-1:0]  Dato1,
  input  logic [DATA_W-1:0]  Dato2,
  input  logic [DATA_W-1:0]  SignExtend,
  input  logic [REG_W-1:0]   Rs,
  input  logic [REG_W-1:0]   Rt,
  input  logic [REG_W-1:0]   Rd,
  input  logic [REG_W-1:0]   Shamt,
  output logic               RegWrite_q,
  output logic               MemToReg_q,
  output logic               MemWrite_q,
  output logic               MemRead_q,
  output logic               Branch_q,
  output logic               ALUSrc_q,
  output logic               RegDst_q,
  output logic [ALUOP_W-1:0] AluOP_q,
  output logic [DATA_W-1:0]  PCResult_q,
  output logic [DATA_W-1:0]  Dato1_q,
  output logic [DATA_W-1:0]  Dato2_q,
  output logic [DATA_W-1:0]  SignExtend_q,
  output logic [REG_W-1:0]   Rs_q,
  output logic [REG_W-1:0]   Rt_q,
  output logic [REG_W-1:0]   Rd_q,
  output logic [REG_W-1:0]   Shamt_q,
  output logic               valid_q,
  output logic               hazard_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  import id_ex_pipe_pkg::*;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  bubble;
  logic  load;

  assign ctrl_d = {RegWrite, MemToReg, MemWrite, MemRead, Branch, ALUSrc, RegDst, AluOP};

`ifdef ID_EX_HAZARD_EN
  logic hazard_raw;

  id_ex_hazard_unit #(
    .REG_W(REG_W)
  ) u_hazard (
    .valid    (valid_q),
    .mem_read (ctrl_q.mem_read),
    .id_valid (id_valid_i),
    .rt_ex    (Rt_q),
    .rs_id    (Rs),
    .rt_id    (Rt),
    .hazard   (hazard_raw)
  );

  assign hazard_o = hazard_raw & ~rst;
`else
  assign hazard_o = 1'b0;
`endif

  // Flush beats stall; a stalled hazard waits and bubbles once the stall lifts.
  assign bubble = flush_i | (~stall_i & hazard_o);
  assign load   = ~flush_i & ~stall_i & ~hazard_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else if (bubble) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      ctrl_q  <= ctrl_d;
      valid_q <= id_valid_i;
    end
  end

  // Data and address fields only move on a real load; bubbles keep them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCResult_q   <= '0;
      Dato1_q      <= '0;
      Dato2_q      <= '0;
      SignExtend_q <= '0;
      Rs_q         <= '0;
      Rt_q         <= '0;
      Rd_q         <= '0;
      Shamt_q      <= '0;
    end else if (load) begin
      PCResult_q   <= PCResult;
      Dato1_q      <= Dato1;
      Dato2_q      <= Dato2;
      SignExtend_q <= SignExtend;
      Rs_q         <= Rs;
      Rt_q         <= Rt;
      Rd_q         <= Rd;
      Shamt_q      <= Shamt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_o <= '0;
    end else if (bubble && (bubble_cnt_o != '1)) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

  assign RegWrite_q = ctrl_q.reg_write;
  assign MemToReg_q = ctrl_q.mem_to_reg;
  assign MemWrite_q = ctrl_q.mem_write;
  assign MemRead_q  = ctrl_q.mem_read;
  assign Branch_q   = ctrl_q.branch;
  assign ALUSrc_q   = ctrl_q.alu_src;
  assign RegDst_q   = ctrl_q.reg_dst;
  assign AluOP_q    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: a driver issues random and directed cycles
// and queues model expectations; a monitor pops and compares them.
module tb_id_ex_pipe;

`ifdef ID_EX_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic        rw, m2r, mw, mr, br, as, rdst;
    logic [2:0]  op;
    logic [31:0] pc, d1, d2, se;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] cnt;
  } snap_t;

  typedef struct packed {
    logic        rst, flush, stall, idv;
    logic        rw, m2r, mw, mr, br, as, rdst;
    logic [2:0]  op;
    logic [31:0] pc, d1, d2, se;
    logic [4:0]  rs, rt, rd, sh;
  } stim_t;

  typedef struct {
    logic       rst;
    logic       haz;
    snap_t      post;
    logic [1:0] cnt2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_i = 1'b0, flush_i = 1'b0, id_valid_i = 1'b0;
  logic reg_write = 1'b0, mem_to_reg = 1'b0, mem_write = 1'b0, mem_read = 1'b0;
  logic branch = 1'b0, alu_src = 1'b0, reg_dst = 1'b0;
  logic [2:0]  alu_op = '0;
  logic [31:0] pc_result = '0, dato1 = '0, dato2 = '0, sign_ext = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;

  logic        rw_q, m2r_q, mw_q, mr_q, br_q, as_q, rdst_q, valid_q, hazard_o;
  logic [2:0]  op_q;
  logic [31:0] pc_q, d1_q, d2_q, se_q;
  logic [4:0]  rs_q, rt_q, rd_q, sh_q;
  logic [15:0] cnt_q;

  logic        rw_2, m2r_2, mw_2, mr_2, br_2, as_2, rdst_2, valid_2, hazard_2;
  logic [2:0]  op_2;
  logic [31:0] pc_2, d1_2, d2_2, se_2;
  logic [4:0]  rs_2, rt_2, rd_2, sh_2;
  logic [1:0]  cnt_2;

  int n_cmp  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  exp_t  sb[$];
  snap_t m;
  logic [1:0] m2;

  always #5 clk = ~clk;

  id_ex_pipe u_dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .RegWrite(reg_write), .MemToReg(mem_to_reg), .MemWrite(mem_write), .MemRead(mem_read),
    .Branch(branch), .ALUSrc(alu_src), .RegDst(reg_dst), .AluOP(alu_op),
    .PCResult(pc_result), .Dato1(dato1), .Dato2(dato2), .SignExtend(sign_ext),
    .Rs(rs), .Rt(rt), .Rd(rd), .Shamt(shamt),
    .RegWrite_q(rw_q), .MemToReg_q(m2r_q), .MemWrite_q(mw_q), .MemRead_q(mr_q),
    .Branch_q(br_q), .ALUSrc_q(as_q), .RegDst_q(rdst_q), .AluOP_q(op_q),
    .PCResult_q(pc_q), .Dato1_q(d1_q), .Dato2_q(d2_q), .SignExtend_q(se_q),
    .Rs_q(rs_q), .Rt_q(rt_q), .Rd_q(rd_q), .Shamt_q(sh_q),
    .valid_q(valid_q), .hazard_o(hazard_o), .bubble_cnt_o(cnt_q)
  );

  id_ex_pipe #(.CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .RegWrite(reg_write), .MemToReg(mem_to_reg), .MemWrite(mem_write), .MemRead(mem_read),
    .Branch(branch), .ALUSrc(alu_src), .RegDst(reg_dst), .AluOP(alu_op),
    .PCResult(pc_result), .Dato1(dato1), .Dato2(dato2), .SignExtend(sign_ext),
    .Rs(rs), .Rt(rt), .Rd(rd), .Shamt(shamt),
    .RegWrite_q(rw_2), .MemToReg_q(m2r_2), .MemWrite_q(mw_2), .MemRead_q(mr_2),
    .Branch_q(br_2), .ALUSrc_q(as_2), .RegDst_q(rdst_2), .AluOP_q(op_2),
    .PCResult_q(pc_2), .Dato1_q(d1_2), .Dato2_q(d2_2), .SignExtend_q(se_2),
    .Rs_q(rs_2), .Rt_q(rt_2), .Rd_q(rd_2), .Shamt_q(sh_2),
    .valid_q(valid_2), .hazard_o(hazard_2), .bubble_cnt_o(cnt_2)
  );

  function automatic snap_t snap_main();
    return {valid_q, rw_q, m2r_q, mw_q, mr_q, br_q, as_q, rdst_q, op_q,
            pc_q, d1_q, d2_q, se_q, rs_q, rt_q, rd_q, sh_q, cnt_q};
  endfunction

  function automatic snap_t snap_w2();
    return {valid_2, rw_2, m2r_2, mw_2, mr_2, br_2, as_2, rdst_2, op_2,
            pc_2, d1_2, d2_2, se_2, rs_2, rt_2, rd_2, sh_2, 14'd0, cnt_2};
  endfunction

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Small register numbers so load-use pairs happen often in random traffic.
  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = 1'b0;
    s.flush = ($urandom_range(9) == 0);
    s.stall = ($urandom_range(6) == 0);
    s.idv   = ($urandom_range(4) != 0);
    {s.rw, s.m2r, s.mw, s.br, s.as, s.rdst} = 6'($urandom);
    s.mr = $urandom_range(1);
    s.op = 3'($urandom);
    s.pc = $urandom; s.d1 = $urandom; s.d2 = $urandom; s.se = $urandom;
    s.rs = 5'($urandom_range(7)); s.rt = 5'($urandom_range(7));
    s.rd = 5'($urandom); s.sh = 5'($urandom);
    return s;
  endfunction

  function automatic stim_t quiet(input stim_t s);
    stim_t q = s;
    q.flush = 1'b0; q.stall = 1'b0; q.idv = 1'b1;
    return q;
  endfunction

  task automatic apply_stimulus(input stim_t s);
    exp_t e;
    logic haz;
    @(negedge clk);
    flush_i = s.flush; stall_i = s.stall; id_valid_i = s.idv;
    reg_write = s.rw; mem_to_reg = s.m2r; mem_write = s.mw; mem_read = s.mr;
    branch = s.br; alu_src = s.as; reg_dst = s.rdst; alu_op = s.op;
    pc_result = s.pc; dato1 = s.d1; dato2 = s.d2; sign_ext = s.se;
    rs = s.rs; rt = s.rt; rd = s.rd; shamt = s.sh;
    if (s.rst) begin
      #1 rst = 1'b1;
    end else begin
      rst = 1'b0;
    end
    e.rst = s.rst;
    if (s.rst) begin
      m = '0; m2 = '0; haz = 1'b0;
    end else begin
      haz = HAZ_EN && m.valid && m.mr && s.idv && (m.rt != 0) && (m.rt == s.rs || m.rt == s.rt);
      if (s.flush || (!s.stall && haz)) begin
        m.valid = 1'b0;
        {m.rw, m.m2r, m.mw, m.mr, m.br, m.as, m.rdst, m.op} = '0;
        if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
        if (m2 != 2'd3) m2 = m2 + 2'd1;
      end else if (!s.stall) begin
        m.valid = s.idv;
        {m.rw, m.m2r, m.mw, m.mr, m.br, m.as, m.rdst, m.op} =
          {s.rw, s.m2r, s.mw, s.mr, s.br, s.as, s.rdst, s.op};
        {m.pc, m.d1, m.d2, m.se, m.rs, m.rt, m.rd, m.sh} =
          {s.pc, s.d1, s.d2, s.se, s.rs, s.rt, s.rd, s.sh};
      end
    end
    e.haz = haz; e.post = m; e.cnt2 = m2;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    snap_t w2exp;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output("hazard_o", 256'(hazard_o), 256'(e.haz));
        check_output("hazard_w2", 256'(hazard_2), 256'(e.haz));
        if (e.rst) begin
          check_output("async_reset", 256'(snap_main()), 256'(0));
          check_output("async_reset_w2", 256'(snap_w2()), 256'(0));
        end
        @(posedge clk);
        #1;
        check_output("state", 256'(snap_main()), 256'(e.post));
        w2exp = e.post;
        w2exp.cnt = {14'd0, e.cnt2};
        check_output("state_cnt_w2", 256'(snap_w2()), 256'(w2exp));
      end
    end
  end

  initial begin : driver
    stim_t s;
    m = '0; m2 = '0;
    repeat (3) apply_stimulus(quiet(rand_stim()));

    s = rand_stim(); s.rst = 1'b1;
    apply_stimulus(s);

    s = quiet(rand_stim()); s.d1 = 32'h12345678; s.rw = 1'b1; s.mr = 1'b0;
    apply_stimulus(s);

    s = quiet(rand_stim()); s.mr = 1'b1; s.rt = 5'd5; s.rs = 5'd1;
    apply_stimulus(s);
    s = quiet(rand_stim()); s.mr = 1'b0; s.rs = 5'd5; s.rt = 5'd2;
    apply_stimulus(s);
    apply_stimulus(s);

    s = quiet(rand_stim()); s.mr = 1'b1; s.rt = 5'd0; s.rs = 5'd3;
    apply_stimulus(s);
    s = quiet(rand_stim()); s.mr = 1'b0; s.rs = 5'd0; s.rt = 5'd0;
    apply_stimulus(s);

    s = quiet(rand_stim()); s.mr = 1'b1; s.rt = 5'd7; s.rs = 5'd1;
    apply_stimulus(s);
    s = quiet(rand_stim()); s.mr = 1'b0; s.rs = 5'd7; s.rt = 5'd1; s.stall = 1'b1;
    repeat (3) apply_stimulus(s);
    s.stall = 1'b0;
    apply_stimulus(s);
    apply_stimulus(s);

    s = quiet(rand_stim()); s.flush = 1'b1; s.stall = 1'b1;
    apply_stimulus(s);

    repeat (400) apply_stimulus(rand_stim());

    s = rand_stim(); s.rst = 1'b1;
    apply_stimulus(s);
    repeat (5) begin
      s = rand_stim(); s.flush = 1'b1;
      apply_stimulus(s);
    end
    repeat (20) apply_stimulus(rand_stim());

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (done);
      #100000;
    join_any
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL watchdog: got timeout, expected driver completion");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
